// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling FSM and a
// valid/ack holding register with framing and overrun error pulses.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             ferr_q, ferr_d;
    logic             oerr_q, oerr_d;
    logic             rxs;

    assign rxs = sync2_q;

    always_comb begin
        state_d = state_q;
        sync1_d = uart_rxd;
        sync2_d = sync1_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~rx_ack;
        ferr_d  = 1'b0;
        oerr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        // An ack landing on this cycle consumes the old byte, so no overrun.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        oerr_d  = valid_q & ~rx_ack;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rxs) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign rx_busy     = busy_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; expected bytes are queued
// as frames are driven and popped when the receiver presents them.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       uart_rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;

    int vectors     = 0;
    int miscompares = 0;

    // Edge count and event bookkeeping, sampled 1 ns after each rising edge.
    int cyc       = 0;
    int v_rise    = -1;
    int b_rise    = -1;
    int b_fall    = -1;
    int vrise_cnt = 0;
    int brise_cnt = 0;
    int fe_cnt    = 0;
    int ov_cnt    = 0;
    logic v_prev  = 1'b0;
    logic b_prev  = 1'b0;

    int        e0;
    logic [7:0] exp_q[$];

    uart_rx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .uart_rxd   (uart_rxd),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    // A level first seen after edge N is reported as seen by sampling edge N+1.
    always begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (rx_valid && !v_prev) begin v_rise = cyc + 1; vrise_cnt = vrise_cnt + 1; end
        if (rx_busy && !b_prev)  begin b_rise = cyc + 1; brise_cnt = brise_cnt + 1; end
        if (!rx_busy && b_prev)  b_fall = cyc + 1;
        if (frame_err)   fe_cnt = fe_cnt + 1;
        if (overrun_err) ov_cnt = ov_cnt + 1;
        v_prev = rx_valid;
        b_prev = rx_busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t, required < 200000 ns", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a falling edge; returns at the falling edge ending the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic ack_at_stop);
        if (stop) exp_q.push_back(b);
        uart_rxd = 1'b0;
        e0 = cyc + 1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (10) @(negedge clk);
        end
        uart_rxd = stop;
        if (ack_at_stop) begin
            repeat (7) @(negedge clk);
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic check_byte(input string tag);
        logic [7:0] exp;
        int n;
        n = 0;
        while (!rx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_valid) begin
            chk({tag, "_timeout"}, 32'(rx_valid), 32'd1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 32'(rx_data), 32'hFFFF_FFFF);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, 32'(rx_data), 32'(exp));
        end
    endtask

    task automatic ack_byte(input string tag);
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        chk(tag, 32'(rx_valid), 32'd0);
    endtask

    initial begin
        int fe0, ov0, br0, vr0;

        reset_n  = 1'b0;
        uart_rxd = 1'b1;
        rx_ack   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(rx_data),     32'h00);
        chk("rst_valid", 32'(rx_valid),    32'd0);
        chk("rst_busy",  32'(rx_busy),     32'd0);
        chk("rst_ferr",  32'(frame_err),   32'd0);
        chk("rst_oerr",  32'(overrun_err), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte with latency checks.
        send_byte(8'hA5, 1'b1, 1'b0);
        check_byte("a5_data");
        chk("a5_valid_rise", 32'(v_rise), 32'(e0 + 98));
        chk("a5_busy_rise",  32'(b_rise), 32'(e0 + 3));
        chk("a5_busy_fall",  32'(b_fall), 32'(e0 + 98));
        chk("a5_ferr_cnt",   32'(fe_cnt), 32'd0);
        chk("a5_oerr_cnt",   32'(ov_cnt), 32'd0);
        ack_byte("a5_ack_clears");
        @(negedge clk);
        chk("ack_idle_ignored", 32'(rx_valid), 32'd0);

        // Glitch shorter than half a bit.
        br0 = brise_cnt; vr0 = vrise_cnt;
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_busy_pulse", 32'(brise_cnt - br0), 32'd1);
        chk("glitch_idle",       32'(rx_busy),          32'd0);
        chk("glitch_no_valid",   32'(vrise_cnt - vr0),  32'd0);
        chk("glitch_ferr",       32'(fe_cnt),           32'd0);
        chk("glitch_oerr",       32'(ov_cnt),           32'd0);

        // Framing error, line held low into break, then a good frame.
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("fe_pulse_cnt",  32'(fe_cnt),   32'd1);
        chk("fe_valid",      32'(rx_valid), 32'd0);
        chk("fe_data_kept",  32'(rx_data),  32'hA5);
        chk("fe_in_break",   32'(rx_busy),  32'd1);
        uart_rxd = 1'b1;
        repeat (5) @(negedge clk);
        chk("fe_break_exit", 32'(rx_busy),  32'd0);
        send_byte(8'h11, 1'b1, 1'b0);
        check_byte("after_fe_data");
        chk("after_fe_ferr", 32'(fe_cnt), 32'd1);
        ack_byte("x11_ack");

        // Overrun: two back-to-back frames, never acknowledged.
        ov0 = ov_cnt;
        send_byte(8'h01, 1'b1, 1'b0);
        check_byte("ovr_first");
        chk("ovr_none_yet", 32'(ov_cnt - ov0), 32'd0);
        send_byte(8'h02, 1'b1, 1'b0);
        check_byte("ovr_second");
        chk("ovr_pulse_cnt", 32'(ov_cnt - ov0), 32'd1);
        chk("ovr_valid",     32'(rx_valid),     32'd1);
        ack_byte("x02_ack");

        // Ack arriving on the stop-sample cycle of the next byte.
        ov0 = ov_cnt;
        send_byte(8'h55, 1'b1, 1'b0);
        check_byte("coll_first");
        send_byte(8'hAA, 1'b1, 1'b1);
        chk("coll_valid", 32'(rx_valid), 32'd1);
        check_byte("coll_data");
        chk("coll_no_oerr", 32'(ov_cnt - ov0), 32'd0);

        // Reset during data bit 4, then a clean frame.
        uart_rxd = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = 1'b1;
            repeat (10) @(negedge clk);
        end
        uart_rxd = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy_before", 32'(rx_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_data",  32'(rx_data),     32'h00);
        chk("mid_rst_valid", 32'(rx_valid),    32'd0);
        chk("mid_rst_busy",  32'(rx_busy),     32'd0);
        chk("mid_rst_flags", 32'({frame_err, overrun_err}), 32'd0);
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        vr0 = vrise_cnt; fe0 = fe_cnt;
        repeat (30) @(negedge clk);
        chk("mid_post_valid", 32'(rx_valid), 32'd0);
        chk("mid_post_busy",  32'(rx_busy),  32'd0);
        send_byte(8'h7E, 1'b1, 1'b0);
        check_byte("mid_7e");
        chk("mid_one_byte", 32'(vrise_cnt - vr0), 32'd1);
        chk("mid_no_ferr",  32'(fe_cnt - fe0),    32'd0);
        chk("queue_drained", 32'(exp_q.size()),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
